// File: rtl/uart_tx_arbiter_if.sv
// Byte-requester and UART-driver handshake bundle for uart_tx_arbiter.
// master = arbiter side, slave = environment side (requesters plus transmitter).
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               uart_start;
  logic [7:0]         uart_data;
  logic               uart_busy;
  logic               uart_ready;

  modport master (
    input  req_valid, req_data, uart_busy, uart_ready,
    output req_ready, uart_start, uart_data
  );

  modport slave (
    output req_valid, req_data, uart_busy, uart_ready,
    input  req_ready, uart_start, uart_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte sources, with start-to-busy watchdog.
// Define UART_ARB_PRIO_EN to make requester 0 strict high priority over a round-robin of 1..N_REQ-1.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arbiter_if.master        bus,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     arb_active,
  output logic                     tx_timeout
);
  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC);
`ifdef UART_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [7:0]       data_q, data_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;

  logic [7:0]       byte_w [N_REQ];
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic             arb_en;
  logic [N_REQ-1:0] req_ready_c;
  logic             uart_start_c;
  logic             tx_timeout_c;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_bytes
      assign byte_w[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Pointer after serving g; with priority enabled, requester 0 never moves it and 1..N-1 wrap to 1.
  function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] g, input logic [IDW-1:0] cur);
    if (PRIO_EN && g == '0) return cur;
    if (int'(g) == N_REQ - 1) return PRIO_EN ? IDW'(1) : '0;
    return g + IDW'(1);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (PRIO_EN && bus.req_valid[0]) begin
      win_found = 1'b1;
    end
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && bus.req_valid[cand] && !(PRIO_EN && cand == '0)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign arb_en = bus.uart_ready && !bus.uart_busy;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    data_d       = data_q;
    wd_cnt_d     = wd_cnt_q;
    req_ready_c  = '0;
    uart_start_c = 1'b0;
    tx_timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_en && win_found) begin
          req_ready_c[win_idx] = 1'b1;
          data_d               = byte_w[win_idx];
          grant_d              = win_idx;
          state_d              = START;
        end
      end
      START: begin
        uart_start_c = 1'b1;
        wd_cnt_d     = '0;
        state_d      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.uart_busy) begin
          state_d = WAIT_DONE;
        end else if (wd_cnt_q == WDW'(TIMEOUT_CYC - 1)) begin
          // Transmitter never responded: drop the byte and move on.
          tx_timeout_c = 1'b1;
          rr_ptr_d     = next_ptr(grant_q, rr_ptr_q);
          state_d      = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WDW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_busy && bus.uart_ready) begin
          rr_ptr_d = next_ptr(grant_q, rr_ptr_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      data_q   <= 8'h00;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.uart_start = uart_start_c;
  assign bus.uart_data  = data_q;
  assign grant_id       = grant_q;
  assign arb_active     = (state_q != IDLE);
  assign tx_timeout     = tx_timeout_c;
endmodule
